// File: rtl/freq_gate_controller_if.sv
// freq_gate_controller_if
//   Groups the measurement signal, run control and result outputs of the
//   frequency gate controller.
//   SignalIn : measured signal, asynchronous to the controller clock
//   Enable   : high runs continuous measure cycles, low parks the controller
//   Binary   : latched edge count (clamped to MAX_COUNT), feeds the BCD path
//   Overflow : latched count exceeded MAX_COUNT
//   Valid    : one-cycle pulse when Binary/Overflow take a new result
//   Gating   : high while the gate window is open
//   master drives SignalIn/Enable; slave (the controller) drives the results.
interface freq_gate_controller_if;
  logic        SignalIn;
  logic        Enable;
  logic [31:0] Binary;
  logic        Overflow;
  logic        Valid;
  logic        Gating;

  modport master (
    output SignalIn,
    output Enable,
    input  Binary,
    input  Overflow,
    input  Valid,
    input  Gating
  );

  modport slave (
    input  SignalIn,
    input  Enable,
    output Binary,
    output Overflow,
    output Valid,
    output Gating
  );
endinterface

// File: rtl/freq_gate_controller.sv
// freq_gate_controller
//   Counts rising edges of SignalIn over a gate window of GATE_CYCLES clocks,
//   latches the count (clamped to MAX_COUNT, with Overflow), then waits
//   HOLD_CYCLES clocks before the next window while Enable stays high.
//   Clock : sole clock, rising edge
//   Reset : synchronous, active-high
//   bus   : slave side of freq_gate_controller_if (SignalIn, Enable in;
//           Binary, Overflow, Valid, Gating out)
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   S_IDLE  | parked, Gating low, waits for Enable
//   S_GATE  | window open, edge pulses counted, timer runs GATE_CYCLES
//   S_LATCH | single cycle, new result visible with Valid high
//   S_HOLD  | idle gap of HOLD_CYCLES cycles before the next window
module freq_gate_controller #(
  parameter int unsigned GATE_CYCLES = 100000000,
  parameter int unsigned HOLD_CYCLES = 1000000,
  parameter int unsigned MAX_COUNT   = 9999
) (
  input logic                    Clock,
  input logic                    Reset,
  freq_gate_controller_if.slave  bus
);

  localparam int unsigned SPAN = (GATE_CYCLES > HOLD_CYCLES) ? GATE_CYCLES : HOLD_CYCLES;
  // The timer is loaded with CYCLES-1 and counts down to 0.
  localparam int TW = (SPAN < 2) ? 1 : $clog2(SPAN);
  localparam logic [TW-1:0] GATE_LOAD = TW'(GATE_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LOAD = TW'((HOLD_CYCLES == 0) ? 0 : HOLD_CYCLES - 1);
  localparam logic [31:0]   MAX_VAL   = 32'(MAX_COUNT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GATE  = 2'd1,
    S_LATCH = 2'd2,
    S_HOLD  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [31:0]   count_q, count_d;
  logic [31:0]   binary_q, binary_d;
  logic          overflow_q, overflow_d;
  logic          valid_q, valid_d;
  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          sync3_q, sync3_d;
  logic          edge_pulse;

  assign edge_pulse = sync2_q & ~sync3_q;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    count_d    = count_q;
    binary_d   = binary_q;
    overflow_d = overflow_q;
    valid_d    = 1'b0;
    sync1_d    = bus.SignalIn;
    sync2_d    = sync1_q;
    sync3_d    = sync2_q;

    case (state_q)
      S_IDLE: begin
        if (bus.Enable) begin
          state_d = S_GATE;
          timer_d = GATE_LOAD;
          count_d = '0;
        end
      end

      S_GATE: begin
        if (!bus.Enable) begin
          state_d = S_IDLE;
        end else begin
          if (edge_pulse && (count_q != '1)) begin
            count_d = count_q + 32'd1;
          end
          if (timer_q == '0) begin
            // Result registers load on the edge into LATCH so that the
            // new value and the Valid pulse are visible during LATCH;
            // count_d already includes an edge in the final gate cycle.
            state_d = S_LATCH;
            valid_d = 1'b1;
            if (count_d > MAX_VAL) begin
              binary_d   = MAX_VAL;
              overflow_d = 1'b1;
            end else begin
              binary_d   = count_d;
              overflow_d = 1'b0;
            end
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
      end

      S_LATCH: begin
        if (HOLD_CYCLES == 0) begin
          if (bus.Enable) begin
            state_d = S_GATE;
            timer_d = GATE_LOAD;
            count_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_HOLD;
          timer_d = HOLD_LOAD;
        end
      end

      S_HOLD: begin
        if (!bus.Enable) begin
          state_d = S_IDLE;
        end else if (timer_q == '0) begin
          state_d = S_GATE;
          timer_d = GATE_LOAD;
          count_d = '0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      count_q    <= '0;
      binary_q   <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sync3_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      count_q    <= count_d;
      binary_q   <= binary_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      sync3_q    <= sync3_d;
    end
  end

  assign bus.Binary   = binary_q;
  assign bus.Overflow = overflow_q;
  assign bus.Valid    = valid_q;
  assign bus.Gating   = (state_q == S_GATE);

endmodule
